// File: rtl/proc_pkg.sv
// Shared processor definitions: word width, opcode encodings and the sequencer state set.
// The control unit decodes ir[8:6] against the same OP_* constants.
package proc_pkg;

   localparam int INSTR_W = 9;

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_SUB  = 3'b001;
   localparam logic [2:0] OP_NAN  = 3'b010;
   localparam logic [2:0] OP_JMP  = 3'b011;
   localparam logic [2:0] OP_OUT  = 3'b100;
   localparam logic [2:0] OP_LDI  = 3'b101;
   localparam logic [2:0] OP_HALT = 3'b110;
   localparam logic [2:0] OP_REP  = 3'b111;

   typedef enum logic [2:0] {
      SEQ_IDLE      = 3'd0,
      SEQ_FETCH     = 3'd1,
      SEQ_FETCH_IMM = 3'd2,
      SEQ_EXEC      = 3'd3,
      SEQ_HALTED    = 3'd4
   } seq_state_e;

   function automatic logic [2:0] opcode_of(input logic [INSTR_W-1:0] word);
      return word[INSTR_W-1:INSTR_W-3];
   endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program-memory fetch port between the sequencer (master) and program memory (slave).
// Handshake: master raises mem_req with mem_addr and holds both until a cycle where
// mem_ack=1; that cycle carries mem_rdata and completes the fetch. mem_ack with mem_req=0 means nothing.
interface instr_sequencer_if #(
   parameter int ADDR_W = 5
) ();
   import proc_pkg::*;

   logic                mem_req;
   logic [ADDR_W-1:0]   mem_addr;
   logic                mem_ack;
   logic [INSTR_W-1:0]  mem_rdata;

   modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
   modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);

endinterface

// File: rtl/instr_sequencer_step_counter.sv
// Two-bit execute-step counter; o_tc flags the last step (11).
module step_counter (
   input  logic       i_clk,
   input  logic       i_resetn,
   input  logic       i_clear,
   input  logic       i_enable,
   output logic [1:0] o_cont,
   output logic       o_tc
);

   logic [1:0] r_cnt;

   always_ff @(posedge i_clk or posedge i_resetn) begin
      if (i_resetn) begin
         r_cnt <= 2'b00;
      end else if (i_clear) begin
         r_cnt <= 2'b00;
      end else if (i_enable) begin
         r_cnt <= r_cnt + 2'd1;
      end
   end

   assign o_cont = r_cnt;
   assign o_tc   = (r_cnt == 2'b11);

endmodule

// File: rtl/instr_sequencer.sv
// Fetch-and-step sequencer: owns pc/ir/imm, fetches over the memory handshake and
// walks the control unit through four execute steps; JMP and HALT resolve without steps.
module instr_sequencer
   import proc_pkg::*;
#(
   parameter int ADDR_W = 5
) (
   input  logic                i_clk,
   input  logic                i_resetn,
   input  logic                i_run,
   instr_sequencer_if.master   mem,
   output logic [INSTR_W-1:0]  o_ir,
   output logic [INSTR_W-1:0]  o_imm,
   output logic [1:0]          o_cont,
   output logic                o_step_valid,
   output logic                o_busy,
   output logic                o_halted,
   output logic [2:0]          o_dbg_state,
   output logic [ADDR_W-1:0]   o_dbg_pc
);

   localparam logic [2:0] S_IDLE      = 3'(SEQ_IDLE);
   localparam logic [2:0] S_FETCH     = 3'(SEQ_FETCH);
   localparam logic [2:0] S_FETCH_IMM = 3'(SEQ_FETCH_IMM);
   localparam logic [2:0] S_EXEC      = 3'(SEQ_EXEC);
   localparam logic [2:0] S_HALTED    = 3'(SEQ_HALTED);

   logic [2:0]          r_state;
   logic [ADDR_W-1:0]   r_pc;
   logic [INSTR_W-1:0]  r_ir;
   logic [INSTR_W-1:0]  r_imm;

   logic                w_fetching;
   logic                w_in_exec;
   logic [2:0]          w_op;
   logic [ADDR_W-1:0]   w_pc_inc;
   logic [1:0]          w_cnt;
   logic                w_tc;

   assign w_fetching = (r_state == S_FETCH) || (r_state == S_FETCH_IMM);
   assign w_in_exec  = (r_state == S_EXEC);
   assign w_op       = opcode_of(mem.mem_rdata);
   assign w_pc_inc   = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Held clear outside EXEC so the first execute cycle always shows step 00.
   step_counter u_step_counter (
      .i_clk    (i_clk),
      .i_resetn (i_resetn),
      .i_clear  (!w_in_exec),
      .i_enable (w_in_exec),
      .o_cont   (w_cnt),
      .o_tc     (w_tc)
   );

   always_ff @(posedge i_clk or posedge i_resetn) begin
      if (i_resetn) begin
         r_state <= S_IDLE;
         r_pc    <= '0;
         r_ir    <= '0;
         r_imm   <= '0;
      end else begin
         case (r_state)
            S_IDLE, S_HALTED: begin
               if (i_run) r_state <= S_FETCH;
            end
            S_FETCH: begin
               if (mem.mem_ack) begin
                  r_ir <= mem.mem_rdata;
                  // JMP keeps requesting; the next fetch goes to the truncated target.
                  if (w_op == OP_JMP) begin
                     r_pc    <= mem.mem_rdata[ADDR_W-1:0];
                     r_state <= S_FETCH;
                  end else begin
                     r_pc <= w_pc_inc;
                     case (w_op)
                        OP_LDI:  r_state <= S_FETCH_IMM;
                        OP_HALT: r_state <= S_HALTED;
                        default: r_state <= S_EXEC;
                     endcase
                  end
               end
            end
            S_FETCH_IMM: begin
               if (mem.mem_ack) begin
                  r_imm   <= mem.mem_rdata;
                  r_pc    <= w_pc_inc;
                  r_state <= S_EXEC;
               end
            end
            S_EXEC: begin
               if (w_tc) r_state <= S_FETCH;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign mem.mem_req  = w_fetching;
   assign mem.mem_addr = r_pc;

   assign o_ir         = r_ir;
   assign o_imm        = r_imm;
   assign o_cont       = w_in_exec ? w_cnt : 2'b00;
   assign o_step_valid = w_in_exec;
   assign o_busy       = (r_state != S_IDLE) && (r_state != S_HALTED);
   assign o_halted     = (r_state == S_HALTED);
   assign o_dbg_state  = r_state;
   assign o_dbg_pc     = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: program-memory model with programmable ack delay,
// scoreboard queues for fetch addresses and execute steps, directed checks on reset/JMP/LDI/wrap.
module tb_instr_sequencer;
   import proc_pkg::*;

   localparam int ADDR_W = 5;

   logic                clk;
   logic                resetn;
   logic                run;
   logic [INSTR_W-1:0]  ir;
   logic [INSTR_W-1:0]  imm;
   logic [1:0]          cont;
   logic                step_valid;
   logic                busy;
   logic                halted;
   logic [2:0]          dbg_state;
   logic [ADDR_W-1:0]   dbg_pc;

   logic [INSTR_W-1:0]  pmem [32];
   int                  ack_delay;
   int                  wcnt;
   logic                stray_ack;

   logic [ADDR_W-1:0]   exp_addr_q[$];
   logic [19:0]         exp_q[$];

   int n_cmp;
   int n_fail;

   instr_sequencer_if #(.ADDR_W(ADDR_W)) mem_if ();

   instr_sequencer #(.ADDR_W(ADDR_W)) dut (
      .i_clk        (clk),
      .i_resetn     (resetn),
      .i_run        (run),
      .mem          (mem_if),
      .o_ir         (ir),
      .o_imm        (imm),
      .o_cont       (cont),
      .o_step_valid (step_valid),
      .o_busy       (busy),
      .o_halted     (halted),
      .o_dbg_state  (dbg_state),
      .o_dbg_pc     (dbg_pc)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- program memory model ----------------
   assign mem_if.mem_rdata = pmem[mem_if.mem_addr];
   assign mem_if.mem_ack   = (mem_if.mem_req && (wcnt == ack_delay)) || stray_ack;

   always @(posedge clk) begin
      if (!mem_if.mem_req || mem_if.mem_ack) wcnt <= 0;
      else                                   wcnt <= wcnt + 1;
   end

   // ---------------- checking ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard: every completed fetch and every live step is popped against expectations.
   always @(negedge clk) begin
      if (mem_if.mem_req && mem_if.mem_ack) begin
         if (exp_addr_q.size() == 0) chk("fetch_unexpected", 32'(exp_addr_q.size()), 32'd1);
         else                        chk("fetch_addr", 32'(mem_if.mem_addr), 32'(exp_addr_q.pop_front()));
      end
      if (step_valid) begin
         if (exp_q.size() == 0) chk("step_unexpected", 32'(exp_q.size()), 32'd1);
         else                   chk("step_ir_imm_cont", 32'({ir, imm, cont}), 32'(exp_q.pop_front()));
      end
   end

   // ---------------- driver tasks ----------------
   task automatic push_steps(input logic [8:0] e_ir, input logic [8:0] e_imm, input int n);
      for (int s = 0; s < n; s++) exp_q.push_back({e_ir, e_imm, 2'(s)});
   endtask

   task automatic chk_reset_vals(input string pfx);
      chk({pfx, "_req"},   32'(mem_if.mem_req), 32'd0);
      chk({pfx, "_addr"},  32'(mem_if.mem_addr), 32'd0);
      chk({pfx, "_ir"},    32'(ir), 32'd0);
      chk({pfx, "_imm"},   32'(imm), 32'd0);
      chk({pfx, "_cont"},  32'(cont), 32'd0);
      chk({pfx, "_sv"},    32'(step_valid), 32'd0);
      chk({pfx, "_busy"},  32'(busy), 32'd0);
      chk({pfx, "_halt"},  32'(halted), 32'd0);
      chk({pfx, "_pc"},    32'(dbg_pc), 32'd0);
      chk({pfx, "_state"}, 32'(dbg_state), 32'(SEQ_IDLE));
   endtask

   task automatic do_reset();
      @(negedge clk);
      resetn    = 1'b1;
      run       = 1'b0;
      stray_ack = 1'b0;
      ack_delay = 0;
      for (int a = 0; a < 32; a++) pmem[a] = 9'h000;
      @(negedge clk);
      resetn = 1'b0;
   endtask

   task automatic run_pulse();
      @(negedge clk);
      run = 1'b1;
      @(negedge clk);
      run = 1'b0;
   endtask

   task automatic wait_halted(input string tag);
      for (int i = 0; i < 100; i++) begin
         if (halted) break;
         @(negedge clk);
      end
      chk(tag, 32'(halted), 32'd1);
   endtask

   task automatic chk_drained(input string tag);
      chk({tag, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
      chk({tag, "_step_left"}, 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed sequence ----------------
   initial begin
      int n;
      n_cmp = 0; n_fail = 0;
      resetn = 1'b1; run = 1'b0; stray_ack = 1'b0; ack_delay = 0;
      for (int a = 0; a < 32; a++) pmem[a] = 9'h000;
      #3;
      chk_reset_vals("por");
      @(negedge clk);
      resetn = 1'b0;

      // ADD then HALT, zero-wait
      pmem[0] = 9'b000_001_010;
      pmem[1] = 9'b110_000_000;
      exp_addr_q.push_back(5'd0);
      exp_addr_q.push_back(5'd1);
      push_steps(9'h00A, 9'h000, 4);
      run_pulse();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_if.mem_req && mem_if.mem_addr == 5'd1) break;
         n++;
         @(negedge clk);
      end
      chk("add_cycles", 32'(n), 32'd5);
      wait_halted("add_halted");
      chk("add_pc", 32'(dbg_pc), 32'd2);
      chk("add_busy", 32'(busy), 32'd0);
      chk("add_ir_halt", 32'(ir), 32'h180);
      chk_drained("add");

      // LDI with immediate, then HALT
      do_reset();
      pmem[0] = 9'b101_011_000;
      pmem[1] = 9'h1F5;
      pmem[2] = 9'b110_000_000;
      exp_addr_q.push_back(5'd0);
      exp_addr_q.push_back(5'd1);
      exp_addr_q.push_back(5'd2);
      push_steps(9'h158, 9'h1F5, 4);
      run_pulse();
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (mem_if.mem_req && mem_if.mem_addr == 5'd2) break;
         n++;
         @(negedge clk);
      end
      chk("ldi_cycles", 32'(n), 32'd6);
      chk("ldi_pc", 32'(dbg_pc), 32'd2);
      wait_halted("ldi_halted");
      chk("ldi_imm_held", 32'(imm), 32'h1F5);
      chk_drained("ldi");

      // JMP to 7 then HALT
      do_reset();
      pmem[0] = 9'b011_000_111;
      pmem[7] = 9'b110_000_000;
      exp_addr_q.push_back(5'd0);
      exp_addr_q.push_back(5'd7);
      run_pulse();
      chk("jmp_req0", 32'(mem_if.mem_req), 32'd1);
      chk("jmp_addr0", 32'(mem_if.mem_addr), 32'd0);
      @(negedge clk);
      chk("jmp_req1", 32'(mem_if.mem_req), 32'd1);
      chk("jmp_addr1", 32'(mem_if.mem_addr), 32'd7);
      chk("jmp_sv", 32'(step_valid), 32'd0);
      wait_halted("jmp_halted");
      chk("jmp_pc", 32'(dbg_pc), 32'd8);
      chk_drained("jmp");

      // Delayed ack (3 wait cycles), then stray ack while halted
      do_reset();
      ack_delay = 3;
      pmem[0] = 9'b001_001_011;
      pmem[1] = 9'b110_000_000;
      exp_addr_q.push_back(5'd0);
      exp_addr_q.push_back(5'd1);
      push_steps(9'h04B, 9'h000, 4);
      run_pulse();
      for (int k = 0; k < 3; k++) begin
         chk("wait_req", 32'(mem_if.mem_req), 32'd1);
         chk("wait_addr", 32'(mem_if.mem_addr), 32'd0);
         chk("wait_cont", 32'(cont), 32'd0);
         chk("wait_ir", 32'(ir), 32'd0);
         @(negedge clk);
      end
      wait_halted("wait_halted");
      chk("wait_pc", 32'(dbg_pc), 32'd2);
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      @(negedge clk);
      chk("stray_halted", 32'(halted), 32'd1);
      chk("stray_pc", 32'(dbg_pc), 32'd2);
      chk("stray_ir", 32'(ir), 32'h180);
      chk("stray_req", 32'(mem_if.mem_req), 32'd0);
      chk_drained("wait");

      // pc wrap: JMP to 31, ADD at 31, next fetch at 0
      do_reset();
      stray_ack = 1'b1;
      @(negedge clk);
      stray_ack = 1'b0;
      @(negedge clk);
      chk("idle_stray_busy", 32'(busy), 32'd0);
      chk("idle_stray_pc", 32'(dbg_pc), 32'd0);
      pmem[0]  = 9'b011_011_111;
      pmem[31] = 9'b000_001_010;
      exp_addr_q.push_back(5'd0);
      exp_addr_q.push_back(5'd31);
      exp_addr_q.push_back(5'd0);
      push_steps(9'h00A, 9'h000, 4);
      run_pulse();
      for (int i = 0; i < 20; i++) begin
         if (step_valid) break;
         @(negedge clk);
      end
      chk("wrap_exec_pc", 32'(dbg_pc), 32'd0);
      pmem[0] = 9'b110_000_000;
      wait_halted("wrap_halted");
      chk("wrap_pc", 32'(dbg_pc), 32'd1);
      chk_drained("wrap");

      // Reset asserted during EXEC step 10, with run held high through reset
      do_reset();
      pmem[0] = 9'b010_011_010;
      exp_addr_q.push_back(5'd0);
      push_steps(9'h09A, 9'h000, 3);
      run_pulse();
      for (int i = 0; i < 20; i++) begin
         if (step_valid && cont == 2'b10) break;
         @(negedge clk);
      end
      chk("mid_cont", 32'(cont), 32'd2);
      #2;
      resetn = 1'b1;
      run    = 1'b1;
      #1;
      chk_reset_vals("mid");
      @(negedge clk);
      @(negedge clk);
      chk("mid_run_busy", 32'(busy), 32'd0);
      resetn = 1'b0;
      run    = 1'b0;
      @(negedge clk);
      chk("post_busy", 32'(busy), 32'd0);
      chk("post_req", 32'(mem_if.mem_req), 32'd0);
      chk("post_state", 32'(dbg_state), 32'(SEQ_IDLE));
      chk_drained("mid");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
